writeback_stage: RTL



---
 rtl/writeback_stage_pkg.sv | 37 +++
 rtl/writeback_stage.sv | 117 +++++++++++
 2 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared pipeline definitions for the writeback stage:
// ctrl bits, static-block layout, bypass layout, FSM states.
package writeback_stage_pkg;

  localparam int CTRL_W     = 3;
  localparam int CTRL_WE    = 0;
  localparam int CTRL_LOAD  = 1;
  localparam int CTRL_STORE = 2;

  localparam int BYP_VALID  = 0;

  function automatic int static_w(
    input int reg_addr_w,
    input int addr_w
  );
    return reg_addr_w + CTRL_W + addr_w;
  endfunction

  function automatic int pc_lsb();
    return 0;
  endfunction

  function automatic int ctrl_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int rd_lsb(input int addr_w);
    return addr_w + CTRL_W;
  endfunction

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_COMMIT = 2'd1,
    ST_MEM    = 2'd2
  } wb_state_e;

endpackage

// File: rtl/writeback_stage.sv
// Writeback stage: latches ALU results, runs load/store on a
// ready-handshaked memory, drives reg write port and bypass.
//
// Ports: clk/reset (sync, active-high); W_valid_in, W_result,
// W_store_data, W_static_in from ALU; W_static_out, W_stall
// upstream; W_addr_rd/W_rd/W_We reg write; W_d/W_bypass to
// decode forwarding; mem_* data memory handshake.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int REG_SIZE         = 32,
  parameter int ADDRESS_SIZE     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   W_valid_in,
  input  logic [REG_SIZE-1:0]    W_result,
  input  logic [REG_SIZE-1:0]    W_store_data,
  input  logic [REG_ADDRESS_SIZE+CTRL_W+ADDRESS_SIZE-1:0]
                                 W_static_in,
  output logic [REG_ADDRESS_SIZE+CTRL_W+ADDRESS_SIZE-1:0]
                                 W_static_out,
  output logic                   W_stall,
  output logic [REG_ADDRESS_SIZE-1:0]
                                 W_addr_rd,
  output logic [REG_SIZE-1:0]    W_rd,
  output logic                   W_We,
  output logic [REG_ADDRESS_SIZE:0]
                                 W_d,
  output logic [REG_SIZE-1:0]    W_bypass,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [REG_SIZE-1:0]    mem_wdata,
  input  logic                   mem_ready,
  input  logic [REG_SIZE-1:0]    mem_rdata
);

  localparam int SW = static_w(REG_ADDRESS_SIZE, ADDRESS_SIZE);
  localparam int CL = ctrl_lsb(ADDRESS_SIZE);
  localparam int RL = rd_lsb(ADDRESS_SIZE);

  wb_state_e               state;
  logic [SW-1:0]           static_q;
  logic [REG_SIZE-1:0]     result_q;
  logic [REG_SIZE-1:0]     sdata_q;

  logic [CTRL_W-1:0]       ctrl_q;
  logic [CTRL_W-1:0]       ctrl_in;
  logic [REG_ADDRESS_SIZE-1:0] rd_q;
  logic                    accept;
  logic                    in_mem;
  logic                    commit;

  assign ctrl_q  = static_q[CL +: CTRL_W];
  assign ctrl_in = W_static_in[CL +: CTRL_W];
  assign rd_q    = static_q[RL +: REG_ADDRESS_SIZE];

  assign in_mem  = (state == ST_MEM);
  assign commit  = (state == ST_COMMIT);
  assign accept  = W_valid_in & ~in_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_EMPTY;
      static_q <= '0;
      result_q <= '0;
      sdata_q  <= '0;
    end else begin
      unique case (1'b1)
        in_mem: begin
          if (mem_ready) begin
            // load wins over store when both bits are set
            if (ctrl_q[CTRL_LOAD]) begin
              result_q <= mem_rdata;
              state    <= ST_COMMIT;
            end else begin
              state    <= ST_EMPTY;
            end
          end
        end
        accept: begin
          static_q <= W_static_in;
          result_q <= W_result;
          sdata_q  <= W_store_data;
          if (ctrl_in[CTRL_LOAD] | ctrl_in[CTRL_STORE])
            state <= ST_MEM;
          else
            state <= ST_COMMIT;
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign W_stall      = in_mem;
  assign W_static_out = static_q;

  assign W_We      = commit & ctrl_q[CTRL_WE];
  assign W_addr_rd = rd_q;
  assign W_rd      = result_q;
  assign W_bypass  = result_q;

  always_comb begin
    W_d            = '0;
    W_d[BYP_VALID] = W_We;
    W_d[REG_ADDRESS_SIZE:1] = rd_q;
  end

  assign mem_req   = in_mem;
  assign mem_we    = in_mem & ctrl_q[CTRL_STORE]
                     & ~ctrl_q[CTRL_LOAD];
  assign mem_addr  = in_mem ? result_q[ADDRESS_SIZE-1:0] : '0;
  assign mem_wdata = in_mem ? sdata_q : '0;

endmodule
